crc_stream_engine: RTL and testbench
====================================

// Module: crc_stream_engine
// PURPOSE
//  Parametrised, framed CRC engine: the next generation of the fixed CCITT byte CRC.
//  Polynomial, CRC width, data width, init, reflection and final XOR are all parameters.
//  Processes one DATA_W beat per cycle under a valid/ready handshake, bounded by sof/eof.
//  Emits a held CRC result with a compare flag; sits between packet framer and MAC/checker.
// PARAMETERS
//  DATA_W      8             bits consumed per accepted beat (multiple of 8, 8..64)
//  CRC_W       16            CRC register width (8..32)
//  POLY        16'h1021      generator polynomial, implicit x^CRC_W term omitted
//  INIT        16'hFFFF      register value loaded at each sof
//  XOR_OUT     16'h0000      XORed into final register to form crc_out
//  REFLECT_IN  0             1: bit-reverse each input byte before processing
//  REFLECT_OUT 0             1: bit-reverse whole CRC register before XOR_OUT
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       asynchronous, active-high; all state to reset values
//  in_valid   in   1       beat present
//  in_ready   out  1       engine accepts beat; transfer = in_valid & in_ready
//  in_sof     in   1       beat is first of frame
//  in_eof     in   1       beat is last of frame
//  in_data    in   DATA_W  beat payload; byte 0 = in_data[7:0], processed first
//  cmp_crc    in   CRC_W   expected CRC, sampled on the eof transfer
//  out_valid  out  1       crc_out/crc_match valid, held until out_ready
//  out_ready  in   1       consumer takes result
//  crc_out    out  CRC_W   final CRC of completed frame
//  crc_match  out  1       crc_out == sampled cmp_crc
//  err_pulse  out  1       one-cycle pulse on framing error
//  frame_cnt  out  16      completed frames, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset values: crc_reg=INIT, state=IDLE, in_ready=1, out_valid=0, crc_out=0,
//   crc_match=0, err_pulse=0, frame_cnt=0.
//  FSM IDLE -> RUN on sof transfer w/o eof; IDLE -> DONE on sof+eof transfer;
//   RUN -> DONE on eof transfer; DONE -> IDLE on out_ready (or DONE->RUN/DONE,
//   see overlap rule).
//  Per transfer: crc_reg <= step(sof ? INIT : crc_reg, in_data), processing DATA_W/8
//   bytes in order, MSB-first within a byte (LSB-first if REFLECT_IN). Single cycle.
//  Latency: eof transfer in cycle N -> out_valid=1 in cycle N+1 with crc_out =
//   (REFLECT_OUT ? rev(crc_reg) : crc_reg) ^ XOR_OUT; frame_cnt increments same edge.
//  in_ready = !(out_valid & !out_ready). Result overwrite never occurs; a new frame
//   may start the same cycle the result is consumed (back-to-back, zero bubble).
//  Non-sof beat in IDLE: dropped (no CRC update), err_pulse=1.
//  sof beat in RUN: previous frame aborted silently except err_pulse=1; new frame
//   restarts from INIT with this beat; no result emitted for aborted frame.
//  sof+eof in one beat: single-beat frame, result next cycle.
//  eof without sof in IDLE: dropped, err_pulse=1, no result.
//  Reset mid-frame or with out_valid held: result discarded, back to reset values.
//  Inputs other than in_valid are don't-care when in_valid=0.
// STRUCTURE
//  Package crc_pkg: functions rev_bits/rev_bytes, state enum {IDLE,RUN,DONE},
//   named preset constants (CRC16_CCITT_*, CRC32_ETH_*) for POLY/INIT/XOR_OUT.
//  Sub-module crc_step_comb (combinational, params DATA_W, CRC_W, POLY,
//   REFLECT_IN): unrolled bitwise LFSR next-state; top holds FSM, regs, counter.
// TESTING
//  Defaults, DATA_W=8, frame "123456789" (0x31..0x39) -> crc_out=16'h29B1, match=1.
//  INIT=0 (XMODEM), same frame -> crc_out=16'h31C3.
//  CRC_W=32, POLY=32'h04C11DB7, INIT=XOR_OUT=32'hFFFFFFFF, REFLECT_IN/OUT=1,
//   DATA_W=32 beats "1234","5678" + DATA_W=8 "9" config -> 32'hCBF43926.
//  Hold out_ready=0 after result; second frame offered -> in_ready=0, result and
//   frame_cnt stable; release -> second frame accepted same cycle, correct CRC.
//  sof mid-frame, and non-sof beat in IDLE -> err_pulse 1 cycle each, only the
//   restarted frame produces a result; assert reset mid-frame -> out_valid=0.
//  Random frames/backpressure vs bitwise reference model; frame_cnt wrap at 65536.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared types and helpers for the framed CRC engine: FSM states, bit-reversal
// helpers and the common polynomial presets.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } crc_state_t;

    localparam logic [15:0] CRC16_CCITT_POLY    = 16'h1021;
    localparam logic [15:0] CRC16_CCITT_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC16_CCITT_XOR_OUT = 16'h0000;

    localparam logic [31:0] CRC32_ETH_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC32_ETH_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_ETH_XOR_OUT   = 32'hFFFFFFFF;

    // Full 32-bit reversal; narrower CRCs shift the result down afterwards.
    function automatic logic [31:0] rev_bits(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    function automatic logic [63:0] rev_bytes(input logic [63:0] v);
        logic [63:0] r;
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < 8; i++) r[8*b+i] = v[8*b+7-i];
        return r;
    endfunction

endpackage

// File: rtl/crc_step_comb.sv
// Combinational CRC next-state for one beat: unrolled bit-serial LFSR over
// DATA_W/8 bytes, byte 0 first, MSB-first within a byte unless REFLECT_IN.
module crc_step_comb #(
    parameter int               DATA_W     = 8,
    parameter int               CRC_W      = 16,
    parameter logic [CRC_W-1:0] POLY       = 16'h1021,
    parameter bit               REFLECT_IN = 1'b0
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc_nxt
);

    logic [CRC_W-1:0] crc_v;
    logic             fb;

    // NOTE: blocking assignments here are intentional; crc_v is a chain of
    // intermediate values within one evaluation, not stored state.
    always_comb begin
        crc_v = crc_in;
        fb    = 1'b0;
        for (int b = 0; b < DATA_W / 8; b++) begin
            for (int k = 0; k < 8; k++) begin
                fb    = crc_v[CRC_W-1] ^ data[8*b + (REFLECT_IN ? k : 7 - k)];
                crc_v = {crc_v[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
            end
        end
        crc_nxt = crc_v;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// Framed, parametrised CRC engine: valid/ready beat input bounded by sof/eof,
// held result with compare flag, framing-error pulse and frame counter.
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int               DATA_W      = 8,
    parameter int               CRC_W       = 16,
    parameter logic [CRC_W-1:0] POLY        = CRC16_CCITT_POLY,
    parameter logic [CRC_W-1:0] INIT        = CRC16_CCITT_INIT,
    parameter logic [CRC_W-1:0] XOR_OUT     = CRC16_CCITT_XOR_OUT,
    parameter bit               REFLECT_IN  = 1'b0,
    parameter bit               REFLECT_OUT = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic              in_eof,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CRC_W-1:0]  cmp_crc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_match,
    output logic              err_pulse,
    output logic [15:0]       frame_cnt
);

    crc_state_t       state, state_nxt;
    logic [CRC_W-1:0] crc_reg, crc_seed, crc_next;
    logic [CRC_W-1:0] crc_rev, crc_final;
    logic             xfer, crc_load, frame_done, err_nxt;

    assign out_valid = (state == DONE);
    // The result slot frees up in the same cycle it is consumed, so a new
    // frame can begin with zero bubble.
    assign in_ready  = !(out_valid && !out_ready);
    assign xfer      = in_valid && in_ready;
    assign crc_seed  = in_sof ? INIT : crc_reg;

    crc_step_comb #(
        .DATA_W    (DATA_W),
        .CRC_W     (CRC_W),
        .POLY      (POLY),
        .REFLECT_IN(REFLECT_IN)
    ) u_step (
        .crc_in (crc_seed),
        .data   (in_data),
        .crc_nxt(crc_next)
    );

    assign crc_rev   = CRC_W'(rev_bits(32'(crc_next)) >> (32 - CRC_W));
    assign crc_final = (REFLECT_OUT ? crc_rev : crc_next) ^ XOR_OUT;

    // NOTE: every output of this block gets a default first so no path
    // through the if-tree leaves a signal unassigned (which would infer a latch).
    always_comb begin
        state_nxt  = state;
        crc_load   = 1'b0;
        frame_done = 1'b0;
        err_nxt    = 1'b0;
        if (state == DONE && out_ready) state_nxt = IDLE;
        if (xfer) begin
            if (in_sof || state == RUN) begin
                crc_load = 1'b1;
                err_nxt  = in_sof && (state == RUN);
                if (in_eof) begin
                    state_nxt  = DONE;
                    frame_done = 1'b1;
                end else begin
                    state_nxt  = RUN;
                end
            end else begin
                // Stray mid-frame or eof beat with no open frame: dropped.
                err_nxt = 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments for all registered state so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            crc_reg   <= INIT;
            crc_out   <= '0;
            crc_match <= 1'b0;
            err_pulse <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            state     <= state_nxt;
            err_pulse <= err_nxt;
            if (crc_load) crc_reg <= crc_next;
            if (frame_done) begin
                crc_out   <= crc_final;
                crc_match <= (crc_final == cmp_crc);
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench for crc_stream_engine: frame-level reference model plus
// directed vectors with known CRC check values (CCITT-FALSE, XMODEM, CRC-32).
module tb_crc_stream_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0, out_ready = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic [15:0] cmp16 = 16'h0000;
    logic [31:0] cmp32 = 32'h0;

    logic        a_in_ready, a_out_valid, a_crc_match, a_err_pulse;
    logic [15:0] a_crc_out, a_frame_cnt;
    logic        x_in_ready, x_out_valid, x_crc_match, x_err_pulse;
    logic [15:0] x_crc_out, x_frame_cnt;
    logic        e_in_ready, e_out_valid, e_crc_match, e_err_pulse;
    logic [31:0] e_crc_out;
    logic [15:0] e_frame_cnt;

    logic        w_valid = 1'b0, w_sof = 1'b0, w_eof = 1'b0, w_out_ready = 1'b1;
    logic [31:0] w_data = 32'h0, w_cmp = 32'h0;
    logic        w_in_ready, w_out_valid, w_crc_match, w_err_pulse;
    logic [31:0] w_crc_out;
    logic [15:0] w_frame_cnt;

    always #5 clk = ~clk;

    crc_stream_engine dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_sof(in_sof), .in_eof(in_eof), .in_data(in_data), .cmp_crc(cmp16),
        .out_valid(a_out_valid), .out_ready(out_ready), .crc_out(a_crc_out),
        .crc_match(a_crc_match), .err_pulse(a_err_pulse), .frame_cnt(a_frame_cnt)
    );

    crc_stream_engine #(.INIT(16'h0000)) dut_x (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(x_in_ready),
        .in_sof(in_sof), .in_eof(in_eof), .in_data(in_data), .cmp_crc(cmp16),
        .out_valid(x_out_valid), .out_ready(out_ready), .crc_out(x_crc_out),
        .crc_match(x_crc_match), .err_pulse(x_err_pulse), .frame_cnt(x_frame_cnt)
    );

    crc_stream_engine #(
        .DATA_W(8), .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
        .XOR_OUT(32'hFFFFFFFF), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)
    ) dut_e (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(e_in_ready),
        .in_sof(in_sof), .in_eof(in_eof), .in_data(in_data), .cmp_crc(cmp32),
        .out_valid(e_out_valid), .out_ready(out_ready), .crc_out(e_crc_out),
        .crc_match(e_crc_match), .err_pulse(e_err_pulse), .frame_cnt(e_frame_cnt)
    );

    crc_stream_engine #(
        .DATA_W(32), .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
        .XOR_OUT(32'hFFFFFFFF), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)
    ) dut_w (
        .clk(clk), .reset(reset), .in_valid(w_valid), .in_ready(w_in_ready),
        .in_sof(w_sof), .in_eof(w_eof), .in_data(w_data), .cmp_crc(w_cmp),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .crc_out(w_crc_out),
        .crc_match(w_crc_match), .err_pulse(w_err_pulse), .frame_cnt(w_frame_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;
    bit rand_bp  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Textbook bit-serial CRC over a byte list.
    function automatic logic [31:0] crc_ref(input logic [7:0] q[$], input int w,
                                            input logic [31:0] poly, input logic [31:0] init,
                                            input logic [31:0] xo, input bit refin, input bit refout);
        logic [31:0] mask, c, r;
        logic        bi, fb;
        mask = (w == 32) ? 32'hFFFFFFFF : ((32'd1 << w) - 32'd1);
        c = init & mask;
        foreach (q[j]) begin
            for (int k = 0; k < 8; k++) begin
                bi = refin ? q[j][k] : q[j][7-k];
                fb = c[w-1] ^ bi;
                c  = (c << 1) & mask;
                if (fb) c = c ^ poly;
            end
        end
        if (refout) begin
            r = 32'h0;
            for (int i = 0; i < w; i++) r[w-1-i] = c[i];
            c = r;
        end
        return (c ^ xo) & mask;
    endfunction

    function automatic logic [31:0] ccitt(input logic [7:0] q[$]);
        return crc_ref(q, 16, 32'h1021, 32'hFFFF, 32'h0, 1'b0, 1'b0);
    endfunction

    // Frame-level model of the default (CCITT-FALSE) engine.
    bit          m_in_frame = 1'b0, m_ov = 1'b0, m_match = 1'b0, m_err = 1'b0;
    logic [15:0] m_crc = 16'h0, m_cnt = 16'h0;
    logic [7:0]  m_bytes[$];

    task automatic model_step();
        bit rdy;
        if (reset) begin
            m_in_frame = 1'b0; m_ov = 1'b0; m_err = 1'b0; m_cnt = 16'h0;
            m_bytes.delete();
        end else begin
            rdy   = !(m_ov && !out_ready);
            m_err = 1'b0;
            if (m_ov && out_ready) m_ov = 1'b0;
            if (in_valid && rdy) begin
                if (in_sof) begin
                    if (m_in_frame) m_err = 1'b1;
                    m_bytes.delete();
                    m_bytes.push_back(in_data);
                    m_in_frame = 1'b1;
                end else if (!m_in_frame) begin
                    m_err = 1'b1;
                end else begin
                    m_bytes.push_back(in_data);
                end
                if (m_in_frame && in_eof) begin
                    m_crc      = 16'(ccitt(m_bytes));
                    m_match    = (m_crc == cmp16);
                    m_ov       = 1'b1;
                    m_cnt      = m_cnt + 16'd1;
                    m_in_frame = 1'b0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("in_ready", a_in_ready, !(m_ov && !out_ready));
            check("out_valid", a_out_valid, m_ov);
            check("err_pulse", a_err_pulse, m_err);
            check("frame_cnt", a_frame_cnt, m_cnt);
            check("xmodem_out_valid", x_out_valid, m_ov);
            if (m_ov) begin
                check("crc_out", a_crc_out, m_crc);
                check("crc_match", a_crc_match, m_match);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit sof, input bit eof);
        bit rdy;
        in_valid = 1'b1; in_data = d; in_sof = sof; in_eof = eof;
        for (int t = 0; ; t++) begin
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            rdy = !(m_ov && !out_ready);
            @(posedge clk);
            #1;
            if (rdy) break;
            if (t > 200) begin
                n_checks++; n_errors++;
                $display("FAIL send_timeout: beat not accepted within 200 cycles");
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_sof   = 1'($urandom_range(0, 1));
        in_eof   = 1'($urandom_range(0, 1));
    endtask

    task automatic send_frame(input logic [7:0] q[$]);
        foreach (q[j]) send(q[j], j == 0, j == q.size() - 1);
    endtask

    function automatic void from_str(input string s, output logic [7:0] q[$]);
        q.delete();
        for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
    endfunction

    initial begin
        logic [7:0]  q[$];
        logic [31:0] t32;
        int          len;

        #1;
        cmp_en = 1'b1;
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_crc_out", a_crc_out, 0);
        check("rst_crc_match", a_crc_match, 0);
        check("rst_err_pulse", a_err_pulse, 0);
        check("rst_frame_cnt", a_frame_cnt, 0);
        check("rst_w_out_valid", w_out_valid, 0);
        #12 reset = 1'b0;
        @(posedge clk); #1;

        // Check-value frame on all three byte-wide engines.
        from_str("123456789", q);
        cmp16 = 16'h29B1; cmp32 = 32'hCBF43926;
        send_frame(q);
        check("ccitt_check_value", a_crc_out, 16'h29B1);
        check("ccitt_match", a_crc_match, 1);
        check("xmodem_check_value", x_crc_out, 16'h31C3);
        check("crc32_check_value", e_crc_out, 32'hCBF43926);
        check("crc32_match", e_crc_match, 1);

        // Same frame, wrong expected value.
        cmp16 = 16'h0000;
        send_frame(q);
        check("mismatch_flag", a_crc_match, 0);
        tick();

        // Hold the result; a waiting frame must stall until it is consumed.
        out_ready = 1'b0;
        from_str("AB", q);
        send_frame(q);
        in_valid = 1'b1; in_sof = 1'b1; in_eof = 1'b1; in_data = 8'h31;
        repeat (3) tick();
        check("bp_in_ready", a_in_ready, 0);
        check("bp_out_valid", a_out_valid, 1);
        check("bp_frame_cnt", a_frame_cnt, 3);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        check("bp_release_valid", a_out_valid, 1);
        check("bp_release_cnt", a_frame_cnt, 4);

        // Framing errors: stray beat, stray eof, sof inside a frame.
        send(8'h55, 1'b0, 1'b0);
        check("stray_beat_err", a_err_pulse, 1);
        send(8'h66, 1'b0, 1'b1);
        check("stray_eof_err", a_err_pulse, 1);
        check("stray_eof_no_result", a_out_valid, 0);
        send(8'h31, 1'b1, 1'b0);
        send(8'h32, 1'b0, 1'b0);
        send(8'h31, 1'b1, 1'b0);
        check("restart_err", a_err_pulse, 1);
        cmp16 = 16'h29B1;
        from_str("23456789", q);
        foreach (q[j]) send(q[j], 1'b0, j == q.size() - 1);
        check("restart_crc", a_crc_out, 16'h29B1);
        check("restart_cnt", a_frame_cnt, 5);
        tick();

        // Reset mid-frame, then reset with a held result.
        send(8'h31, 1'b1, 1'b0);
        send(8'h32, 1'b0, 1'b0);
        reset = 1'b1; #2;
        check("rst_mid_out_valid", a_out_valid, 0);
        check("rst_mid_frame_cnt", a_frame_cnt, 0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(8'h31, 1'b1, 1'b1);
        check("held_out_valid", a_out_valid, 1);
        reset = 1'b1; #2;
        check("rst_held_out_valid", a_out_valid, 0);
        check("rst_held_in_ready", a_in_ready, 1);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Random frames under random backpressure.
        rand_bp = 1'b1;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 8);
            q.delete();
            for (int j = 0; j < len; j++) q.push_back(8'($urandom));
            t32 = ccitt(q);
            cmp16 = ($urandom_range(0, 1) == 1) ? t32[15:0] : 16'($urandom);
            send_frame(q);
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_bp = 1'b0;
        out_ready = 1'b1;
        tick(); tick();

        // 32-bit beats on the wide engine: "1234","5678".
        from_str("12345678", q);
        t32 = crc_ref(q, 32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
        w_cmp = t32;
        check("w_in_ready", w_in_ready, 1);
        w_valid = 1'b1; w_sof = 1'b1; w_eof = 1'b0; w_data = 32'h34333231;
        @(posedge clk); #1;
        w_sof = 1'b0; w_eof = 1'b1; w_data = 32'h38373635;
        @(posedge clk); #1;
        w_valid = 1'b0; w_eof = 1'b0;
        check("w_out_valid", w_out_valid, 1);
        check("w_crc_out", w_crc_out, t32);
        check("w_crc_match", w_crc_match, 1);
        @(posedge clk); #1;
        check("w_consumed", w_out_valid, 0);
        check("w_frame_cnt", w_frame_cnt, 1);

        // Back-to-back single-beat frames up to the counter wrap.
        for (int n = 0; n < 70000 && m_cnt != 16'hFFFF; n++) send(8'h31, 1'b1, 1'b1);
        check("cnt_at_max", a_frame_cnt, 16'hFFFF);
        send(8'h31, 1'b1, 1'b1);
        check("cnt_wrapped", a_frame_cnt, 16'h0000);
        check("wrap_out_valid", a_out_valid, 1);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
